// File: rtl/mul_unit_pipelined_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared op / FSM state enums and operand signedness helpers
//               for the iterative Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        MULW   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic arg1_signed(input op_e op);
        return op != MULHU;
    endfunction

    function automatic logic arg2_signed(input op_e op);
        return (op == MUL) || (op == MULH) || (op == MULW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_unit_pipelined_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_unit_pipelined_if
// Description : Request/response handshake bundle of the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_unit_pipelined_if
    import mul_pkg::*;
#(
    parameter int width = 64
) ();
    logic             in_valid;
    logic             in_ready;
    op_e              op;
    logic [width-1:0] arg1;
    logic [width-1:0] arg2;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] result;

    modport master (
        output in_valid, op, arg1, arg2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, arg1, arg2, out_ready,
        output in_ready, out_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/mul_unit_pipelined_booth_round.sv
`default_nettype none
// ============================================================================
// Module      : mul_booth_round
// Description : One combinational radix-2^bits_per_cycle Booth step: adds
//               digit * multiplicand to the running accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_booth_round #(
    parameter int width          = 64,
    parameter int bits_per_cycle = 2
) (
    input  wire logic [bits_per_cycle-1:0] i_window,
    input  wire logic                      i_prev,
    input  wire logic                      i_top,
    input  wire logic [2*width-1:0]        i_mcand,
    input  wire logic [2*width-1:0]        i_acc,
    output logic      [2*width-1:0]        o_acc
);
    // digit = unsigned(window) + prev - 2^k * top; top is the window MSB
    // except on the closing round, where the sign/guard bit takes its place.
    always_comb begin
        o_acc = i_acc;
        if (i_prev) begin
            o_acc = o_acc + i_mcand;
        end
        for (int j = 0; j < bits_per_cycle; j++) begin
            if (i_window[j]) begin
                o_acc = o_acc + (i_mcand << j);
            end
        end
        if (i_top) begin
            o_acc = o_acc - (i_mcand << bits_per_cycle);
        end
    end
endmodule
`default_nettype wire

// File: rtl/mul_unit_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : mul_unit_pipelined
// Description : Iterative Booth multiplier (MUL/MULH/MULHSU/MULHU/MULW) with
//               valid/ready handshake. Define MUL_EARLY_OUT_EN to stop once
//               the remaining multiplier bits are pure sign fill.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_unit_pipelined
    import mul_pkg::*;
#(
    parameter int width          = 64,
    parameter int bits_per_cycle = 2
) (
    input  wire logic           clock,
    input  wire logic           reset,
    input  wire logic           flush,
    mul_unit_pipelined_if.slave bus
);
    localparam int c_ROUNDS   = width / bits_per_cycle;
    localparam int c_ROUNDS_W = (width / 2) / bits_per_cycle;
    localparam int c_CNT_W    = $clog2(c_ROUNDS);

    state_e               r_state;
    op_e                  r_op;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*width-1:0]   r_acc;
    logic [2*width-1:0]   r_mcand;
    logic [width-1:0]     r_mplier;
    logic [width-1:0]     r_result;
    logic                 r_prev;
    logic                 r_guard;
    logic                 r_out_valid;

    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_last_fixed;
    logic                      w_final;
    logic                      w_top;
    logic                      w_ld_guard;
    logic [bits_per_cycle-1:0] w_window;
    logic [2*width-1:0]        w_acc_next;
    logic [2*width-1:0]        w_ld_mcand;
    logic [width-1:0]          w_ld_mplier;
    logic [width-1:0]          w_result_sel;

    assign w_in_ready    = ~flush & ((r_state == IDLE) | ((r_state == DONE) & bus.out_ready));
    assign w_accept      = bus.in_valid & w_in_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

    assign w_window     = r_mplier[bits_per_cycle-1:0];
    assign w_last_fixed = (r_op == MULW) ? (r_cnt == c_CNT_W'(c_ROUNDS_W - 1))
                                         : (r_cnt == c_CNT_W'(c_ROUNDS - 1));

`ifdef MUL_EARLY_OUT_EN
    logic w_rest_fill;
    assign w_rest_fill = (r_mplier[width-1:bits_per_cycle] == {(width-bits_per_cycle){r_guard}});
    assign w_final     = w_last_fixed | w_rest_fill;
`else
    assign w_final     = w_last_fixed;
`endif

    assign w_top = w_final ? r_guard : w_window[bits_per_cycle-1];

    // MULW only needs the low half-word product, so the multiplier is the
    // sign-extended low half and the loop stops halfway.
    always_comb begin
        w_ld_mcand = {{width{arg1_signed(bus.op) & bus.arg1[width-1]}}, bus.arg1};
        if (bus.op == MULW) begin
            w_ld_guard  = bus.arg2[width/2-1];
            w_ld_mplier = {{(width/2){bus.arg2[width/2-1]}}, bus.arg2[width/2-1:0]};
        end else begin
            w_ld_guard  = arg2_signed(bus.op) & bus.arg2[width-1];
            w_ld_mplier = bus.arg2;
        end
    end

    always_comb begin
        w_result_sel = w_acc_next[width-1:0];
        case (r_op)
            MULH, MULHSU, MULHU: w_result_sel = w_acc_next[2*width-1:width];
            MULW:    w_result_sel = {{(width/2){w_acc_next[width/2-1]}}, w_acc_next[width/2-1:0]};
            default: ;
        endcase
    end

    mul_booth_round #(
        .width          (width),
        .bits_per_cycle (bits_per_cycle)
    ) u_booth (
        .i_window (w_window),
        .i_prev   (r_prev),
        .i_top    (w_top),
        .i_mcand  (r_mcand),
        .i_acc    (r_acc),
        .o_acc    (w_acc_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= MUL;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prev      <= 1'b0;
            r_guard     <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << bits_per_cycle;
                    r_mplier <= {{bits_per_cycle{r_guard}}, r_mplier[width-1:bits_per_cycle]};
                    r_prev   <= w_window[bits_per_cycle-1];
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_final) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_result_sel;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_result    <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // An accept can only occur in IDLE or in a completing DONE.
            if (w_accept) begin
                r_state  <= BUSY;
                r_op     <= bus.op;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mcand  <= w_ld_mcand;
                r_mplier <= w_ld_mplier;
                r_guard  <= w_ld_guard;
                r_prev   <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/mul_unit_pipelined.md
MUL_UNIT_PIPELINED -- requirements
Module: mul_unit_pipelined

Interface
REQ-001 SHALL have parameter width, default 64: operand/result width; even, at least 8.
REQ-002 SHALL have parameter bits_per_cycle, default 2: multiplier bits retired per cycle; one of 1, 2, 4; divides width/2.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: abandon any in-flight or held operation.
REQ-006 SHALL have port in_valid, input, 1: operands and op are valid.
REQ-007 SHALL have port in_ready, output, 1: the unit can accept a request this cycle.
REQ-008 SHALL have port op, input, 3: MUL, MULH, MULHSU, MULHU or MULW.
REQ-009 SHALL have port arg1, input, width: multiplicand.
REQ-010 SHALL have port arg2, input, width: multiplier.
REQ-011 SHALL have port out_valid, output, 1: result is valid.
REQ-012 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-013 SHALL have port result, output, width: product slice selected by op.

Function
REQ-014 A request SHALL be accepted on a posedge where in_valid & in_ready & ~flush; arg1, arg2 and op are latched then and never re-sampled.
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 Transitions: IDLE->BUSY on accept; BUSY->DONE after the final round; DONE->IDLE on out_ready without a new accept; DONE->BUSY on out_ready with an accept in the same cycle.
REQ-017 in_ready SHALL equal ~flush & (IDLE | (DONE & out_ready)), giving back-to-back throughput with no bubble.
REQ-018 Signedness SHALL be: MUL and MULH signed x signed; MULHSU arg1 signed x arg2 unsigned; MULHU unsigned x unsigned.
REQ-019 Result SHALL be the low width bits for MUL, the high width bits of the 2*width product for MULH/MULHSU/MULHU, and sign-extended low (width/2) bits of the low-half product for MULW.
REQ-020 The datapath SHALL use a radix-2^bits_per_cycle Booth recoding with one extra sign/guard bit so that the unsigned operands are exact.
REQ-021 Latency from accept to out_valid SHALL be width/bits_per_cycle cycles (32 at defaults), and (width/2)/bits_per_cycle cycles for MULW (16 at defaults).
REQ-022 In DONE, out_valid=1 and result SHALL stay stable until the cycle out_ready=1.
REQ-023 flush SHALL force IDLE on the next posedge from any state and drop out_valid; flush has priority over accept and over the DONE handshake.
REQ-024 In IDLE, result SHALL be 0 and out_valid 0.

Reset
REQ-025 On reset the FSM SHALL be IDLE, the round counter and accumulator 0, out_valid=0, result=0 and in_ready=1 in the following cycle.
REQ-026 reset asserted mid-operation SHALL discard the operation with no out_valid pulse; reset has priority over flush and accept.

Configuration
REQ-027 When macro MUL_EARLY_OUT_EN is defined, BUSY SHALL end after the first completed round where every unprocessed multiplier bit, plus the Booth guard bit, equals the multiplier's sign fill (0 if unsigned); minimum latency is 1 cycle, and results are bit-identical to fixed latency.
REQ-028 When MUL_EARLY_OUT_EN is undefined, latency SHALL be exactly as REQ-021 for all operands.

Structure
REQ-029 Package mul_pkg SHALL hold the op enum (MUL=0, MULH=1, MULHSU=2, MULHU=3, MULW=4) and the FSM state enum.
REQ-030 One Booth step SHALL be a sub-module mul_booth_round (combinational, parametrised by width and bits_per_cycle), instantiated once.

Verification
REQ-031 Test: MUL 3 x 5 at defaults -> out_valid exactly 32 cycles after accept, result 15 (early-out off).
REQ-032 Test: all-ones x all-ones -> MULHU 0xfffffffffffffffe; MULH 0x0; MUL 0x1.
REQ-033 Test: MULW 0x7fffffff x 2 -> result 0xfffffffffffffffe after 16 cycles; MULHSU all-ones x 2 -> 0xffffffffffffffff.
REQ-034 Test: hold out_ready=0 for 10 cycles in DONE -> result stable and in_ready=0; then out_ready=1 with in_valid=1 -> new accept in the same cycle.
REQ-035 Test: flush at cycle 5 of BUSY -> IDLE next cycle, no out_valid; the next request returns the correct result.
REQ-036 Test: with MUL_EARLY_OUT_EN, MUL arg1=0x1234 x arg2=1 -> result 0x1234 in 1 cycle; sweep bits_per_cycle 1/2/4 against a reference model.
